mem_responder: RTL and testbench

- Synthesizable memory-side responder for the Vortex top-level memory port.
- Accepts mem_req_* from the core, performs byte-enabled writes and reads into a local word array, and returns in-order read responses on mem_rsp_* after a fixed latency.
- Read responses are buffered and backpressured.
- Replaces random mem_rsp stimulus in simulation and serves as an on-chip scratch memory in FPGA bring-up.

---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/mem_rsp_fifo.sv | 44 ++++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared widths, response entry type and LFSR helpers for mem_responder.
package mem_responder_pkg;
    localparam int MEM_DATA_WIDTH   = 512;
    localparam int MEM_ADDR_WIDTH   = 26;
    localparam int MEM_TAG_WIDTH    = 7;
    localparam int MEM_BYTEEN_WIDTH = 64;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic [MEM_TAG_WIDTH-1:0]  tag;
        logic [MEM_DATA_WIDTH-1:0] data;
    } rsp_entry_t;

    // Fibonacci form of the x^16+x^14+x^13+x^11+1 polynomial, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction
endpackage

// File: rtl/mem_rsp_fifo.sv
// Response FIFO of rsp_entry_t; wrap-bit pointers give full/empty/count.
module mem_rsp_fifo import mem_responder_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  rsp_entry_t             push_data,
    input  logic                   pop,
    output rsp_entry_t             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    rsp_entry_t store [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PW-1:0]] <= push_data;
    end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: byte-enabled word array, fixed-latency in-order reads.
// Define MEM_RESPONDER_STALL_EN to add LFSR-driven pseudo-random request stalls.
module mem_responder import mem_responder_pkg::*; #(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int TAG_WIDTH  = MEM_TAG_WIDTH,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 4,
    parameter int RSP_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,
    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IDX_W-1:0]      idx;
    logic                  addr_unused;
    logic                  req_fire;
    logic                  rd_fire;
    logic                  rsp_fire;
    logic [LATENCY-1:0]    pipe_valid;
    rsp_entry_t            pipe_entry [LATENCY];
    rsp_entry_t            fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      outstanding_next;
    logic                  stall_next;

    assign idx         = mem_req_addr[IDX_W-1:0];
    assign addr_unused = ^mem_req_addr[ADDR_WIDTH-1:IDX_W];
    assign req_fire    = mem_req_valid && mem_req_ready;
    assign rd_fire     = req_fire && !mem_req_rw;
    assign rsp_fire    = mem_rsp_valid && mem_rsp_ready;

    always_ff @(posedge clk) begin
        if (req_fire && mem_req_rw) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (mem_req_byteen[i]) mem[idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
            end
        end
    end

    // Payload stages carry no reset; only the valids decide what reaches the FIFO.
    always_ff @(posedge clk) begin
        if (rd_fire) pipe_entry[0] <= {mem_req_tag, mem[idx]};
        for (int s = 1; s < LATENCY; s++) pipe_entry[s] <= pipe_entry[s-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= rd_fire;
            for (int s = 1; s < LATENCY; s++) pipe_valid[s] <= pipe_valid[s-1];
        end
    end

    mem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pipe_valid[LATENCY-1]),
        .push_data (pipe_entry[LATENCY-1]),
        .pop       (rsp_fire),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign mem_rsp_valid = !fifo_empty;
    assign mem_rsp_data  = mem_rsp_valid ? fifo_head.data : '0;
    assign mem_rsp_tag   = mem_rsp_valid ? fifo_head.tag  : '0;

    always_comb begin
        outstanding_next = outstanding;
        if (rd_fire && !rsp_fire)      outstanding_next = outstanding + CNT_W'(1);
        else if (!rd_fire && rsp_fire) outstanding_next = outstanding - CNT_W'(1);
    end

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;

    assign lfsr_nxt   = lfsr_next(lfsr);
    assign stall_next = (lfsr_nxt[1:0] == 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_nxt;
    end
`else
    assign stall_next = 1'b0;
`endif

    // Ready is registered from next-state values so it is low in reset and rises on the first edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding   <= '0;
            mem_req_ready <= 1'b0;
        end else begin
            outstanding   <= outstanding_next;
            mem_req_ready <= (outstanding_next < CNT_W'(RSP_DEPTH)) && !stall_next;
        end
    end

`ifndef SYNTHESIS
    a_req_hold: assert property (@(posedge clk) disable iff (!reset)
        (mem_req_valid && !mem_req_ready) |=> mem_req_valid);
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(fifo_full && pipe_valid[LATENCY-1] && !rsp_fire));
    a_credit_cover: assert property (@(posedge clk) disable iff (!reset)
        fifo_count <= outstanding);
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a queue-based reference model.
module tb_mem_responder;
    localparam int DW  = 512;
    localparam int AW  = 26;
    localparam int TW  = 7;
    localparam int MD  = 256;
    localparam int LAT = 4;
    localparam int RD  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mem_req_valid = 1'b0;
    logic          mem_req_rw = 1'b0;
    logic [DW/8-1:0] mem_req_byteen = '0;
    logic [AW-1:0] mem_req_addr = '0;
    logic [DW-1:0] mem_req_data = '0;
    logic [TW-1:0] mem_req_tag = '0;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic [TW-1:0] mem_rsp_tag;
    logic          mem_rsp_ready = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                    .MEM_DEPTH(MD), .LATENCY(LAT), .RSP_DEPTH(RD)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_ready(mem_rsp_ready)
    );

    // Reference model: every accepted read waits in order; t is the first cycle it may be presented.
    typedef struct { logic [TW-1:0] tag; logic [DW-1:0] data; int t; } exp_t;
    exp_t          q[$];
    logic [DW-1:0] model_mem [MD];
    int            cyc, checks, errors;
    logic [15:0]   lfsr_m;
    logic          exp_ready, exp_rvalid;
    logic [TW-1:0] exp_tag;
    logic [DW-1:0] exp_data;

    function automatic logic [DW-1:0] rand512();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic reset_model();
        q.delete();
        cyc = 0;
        lfsr_m = 16'hACE1;
    endtask

    task automatic observe();
        #1;
        exp_ready = (cyc > 0) && (q.size() < RD);
`ifdef MEM_RESPONDER_STALL_EN
        exp_ready = exp_ready && (lfsr_m[1:0] != 2'b00);
`endif
        exp_rvalid = 1'b0;
        exp_tag = '0;
        exp_data = '0;
        if (q.size() > 0) begin
            if (cyc >= q[0].t) begin
                exp_rvalid = 1'b1;
                exp_tag = q[0].tag;
                exp_data = q[0].data;
            end
        end
    endtask

    task automatic advance();
        int a;
        a = int'(mem_req_addr % MD);
        if (exp_rvalid && mem_rsp_ready) void'(q.pop_front());
        if (mem_req_valid && exp_ready) begin
            if (mem_req_rw) begin
                for (int i = 0; i < DW/8; i++)
                    if (mem_req_byteen[i]) model_mem[a][i*8 +: 8] = mem_req_data[i*8 +: 8];
            end else begin
                q.push_back('{mem_req_tag, model_mem[a], cyc + 1 + LAT});
            end
        end
        @(posedge clk);
        cyc++;
        lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        @(negedge clk);
    endtask

    task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [DW/8-1:0] be,
                         input logic [DW-1:0] data, input logic [TW-1:0] tag, output int acc);
        mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = addr;
        mem_req_byteen = be; mem_req_data = data; mem_req_tag = tag;
        acc = -1;
        for (int k = 0; k < 200 && acc < 0; k++) begin
            observe();
            if (exp_ready) acc = cyc;
            advance();
        end
        mem_req_valid = 1'b0;
        checks++;
        if (acc < 0) begin errors++; $display("FAIL issue_timeout addr=%h accepted=no required=yes", addr); end
    endtask

    task automatic test_reset();
        observe();
        checks += 4;
        if (mem_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", mem_req_ready); end
        if (mem_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", mem_rsp_valid); end
        if (mem_rsp_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", mem_rsp_data); end
        if (mem_rsp_tag !== '0) begin errors++; $display("FAIL reset_tag got=%h exp=0", mem_rsp_tag); end
        advance();
        observe();
        checks++;
        if (mem_req_ready !== exp_ready) begin errors++; $display("FAIL reset_release_ready got=%b exp=%b", mem_req_ready, exp_ready); end
        advance();
    endtask

    task automatic test_fill();
        int acc;
        mem_rsp_ready = 1'b1;
        for (int a = 0; a < MD; a++) issue(1'b1, AW'(a), '1, rand512(), '0, acc);
    endtask

    task automatic test_write_read();
        int acc;
        logic want;
        logic [DW-1:0] expv;
        mem_rsp_ready = 1'b1;
        issue(1'b1, 26'h10, '1, {64{8'hA5}}, '0, acc);
        issue(1'b0, 26'h10, '0, '0, 7'h03, acc);
        for (int d = 0; d <= LAT; d++) begin
            observe();
            want = (d == LAT);
            checks++;
            if (mem_rsp_valid !== want) begin errors++; $display("FAIL latency d=%0d rvalid got=%b exp=%b", d, mem_rsp_valid, want); end
            if (want) begin
                checks += 2;
                if (mem_rsp_data !== {64{8'hA5}}) begin errors++; $display("FAIL full_write_data got=%h exp=%h", mem_rsp_data, {64{8'hA5}}); end
                if (mem_rsp_tag !== 7'h03) begin errors++; $display("FAIL full_write_tag got=%h exp=03", mem_rsp_tag); end
            end
            advance();
        end
        issue(1'b1, 26'h10, 64'h1, 512'hFF, '0, acc);
        issue(1'b0, 26'h10, '0, '0, 7'h05, acc);
        for (int k = 0; k < 40; k++) begin observe(); if (mem_rsp_valid) break; advance(); end
        expv = {{63{8'hA5}}, 8'hFF};
        checks += 2;
        if (mem_rsp_data !== expv) begin errors++; $display("FAIL byteen_data got=%h exp=%h", mem_rsp_data, expv); end
        if (mem_rsp_tag !== 7'h05) begin errors++; $display("FAIL byteen_tag got=%h exp=05", mem_rsp_tag); end
        advance();
        issue(1'b1, 26'h100, '1, 512'h1234, '0, acc);
        issue(1'b0, 26'h000, '0, '0, 7'h06, acc);
        for (int k = 0; k < 40; k++) begin observe(); if (mem_rsp_valid) break; advance(); end
        checks++;
        if (mem_rsp_data !== 512'h1234) begin errors++; $display("FAIL wrap_data got=%h exp=1234", mem_rsp_data); end
        advance();
    endtask

    task automatic test_backpressure();
        int acc_n = 0, next_tag = 0, got = 0, first_pop = -1;
        mem_rsp_ready = 1'b0;
        mem_req_rw = 1'b0;
        for (int w = 0; w < 80 && got < 6; w++) begin
            if (w == 20) mem_rsp_ready = 1'b1;
            mem_req_valid = (next_tag < 6);
            mem_req_tag = TW'(next_tag);
            mem_req_addr = AW'(next_tag * 7 + 32);
            observe();
            checks += 2;
            if (mem_req_ready !== exp_ready) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, mem_req_ready, exp_ready); end
            if (mem_rsp_valid !== exp_rvalid) begin errors++; $display("FAIL bp_rvalid cyc=%0d got=%b exp=%b", cyc, mem_rsp_valid, exp_rvalid); end
            if (w == 19) begin
                checks += 2;
                if (acc_n !== 4) begin errors++; $display("FAIL bp_accepted got=%0d exp=4", acc_n); end
                if (mem_req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", mem_req_ready); end
            end
`ifndef MEM_RESPONDER_STALL_EN
            if (first_pop >= 0 && cyc == first_pop + 1) begin
                checks++;
                if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_restore got=%b exp=1", mem_req_ready); end
            end
`endif
            if (mem_rsp_ready && mem_rsp_valid) begin
                checks += 2;
                if (mem_rsp_tag !== TW'(got)) begin errors++; $display("FAIL bp_order got=%0d exp=%0d", mem_rsp_tag, got); end
                if (mem_rsp_data !== exp_data) begin errors++; $display("FAIL bp_data got=%h exp=%h", mem_rsp_data, exp_data); end
                if (got == 0) first_pop = cyc;
                got++;
            end
            if (mem_req_valid && exp_ready) begin acc_n++; next_tag++; end
            advance();
        end
        mem_req_valid = 1'b0;
        checks++;
        if (got !== 6) begin errors++; $display("FAIL bp_responses got=%0d exp=6", got); end
    endtask

    task automatic test_full_stream();
        int t = 0;
        mem_req_rw = 1'b0;
        for (int w = 0; w < 60; w++) begin
            mem_rsp_ready = (w >= 12) && (w < 40);
            mem_req_valid = (w < 40);
            mem_req_tag = TW'(t);
            mem_req_addr = AW'((t * 13) % MD);
            observe();
            checks += 2;
            if (mem_req_ready !== exp_ready) begin errors++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", cyc, mem_req_ready, exp_ready); end
            if (mem_rsp_valid !== exp_rvalid) begin errors++; $display("FAIL stream_rvalid cyc=%0d got=%b exp=%b", cyc, mem_rsp_valid, exp_rvalid); end
            if (exp_rvalid) begin
                checks++;
                if (mem_rsp_tag !== exp_tag || mem_rsp_data !== exp_data)
                    begin errors++; $display("FAIL stream_rsp got tag=%h data=%h exp tag=%h data=%h", mem_rsp_tag, mem_rsp_data, exp_tag, exp_data); end
            end
            if (mem_req_valid && exp_ready) t++;
            if (w == 39) mem_req_valid = 1'b0;
            if (w >= 40) mem_rsp_ready = 1'b1;
            advance();
        end
    endtask

    task automatic test_reset_inflight();
        int acc;
        mem_rsp_ready = 1'b1;
        issue(1'b0, 26'h10, '0, '0, 7'h01, acc);
        issue(1'b0, 26'h20, '0, '0, 7'h02, acc);
        reset = 1'b0;
        #1;
        checks += 4;
        if (mem_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", mem_req_ready); end
        if (mem_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", mem_rsp_valid); end
        if (mem_rsp_data !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", mem_rsp_data); end
        if (mem_rsp_tag !== '0) begin errors++; $display("FAIL rst_tag got=%h exp=0", mem_rsp_tag); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        reset_model();
        for (int d = 0; d < 2 * LAT; d++) begin
            observe();
            checks += 2;
            if (mem_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_stale d=%0d rvalid got=%b exp=0", d, mem_rsp_valid); end
            if (mem_req_ready !== exp_ready) begin errors++; $display("FAIL rst_ready_rise d=%0d got=%b exp=%b", d, mem_req_ready, exp_ready); end
            advance();
        end
        issue(1'b0, 26'h10, '0, '0, 7'h07, acc);
        for (int k = 0; k < 40; k++) begin observe(); if (mem_rsp_valid) break; advance(); end
        checks += 2;
        if (mem_rsp_data !== model_mem[16]) begin errors++; $display("FAIL rst_keep_data got=%h exp=%h", mem_rsp_data, model_mem[16]); end
        if (mem_rsp_tag !== 7'h07) begin errors++; $display("FAIL rst_keep_tag got=%h exp=07", mem_rsp_tag); end
        advance();
    endtask

    task automatic test_random();
        logic hold = 1'b0;
        for (int w = 0; w < 640; w++) begin
            if (!hold) begin
                mem_req_valid = ($urandom_range(0, 3) != 0) && (w < 600);
                mem_req_rw = 1'($urandom_range(0, 1));
                mem_req_addr = AW'($urandom);
                mem_req_byteen = {$urandom, $urandom};
                mem_req_data = rand512();
                mem_req_tag = TW'($urandom);
            end
            mem_rsp_ready = (w >= 600) || ($urandom_range(0, 3) != 0);
            observe();
            checks += 2;
            if (mem_req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, mem_req_ready, exp_ready); end
            if (mem_rsp_valid !== exp_rvalid) begin errors++; $display("FAIL rand_rvalid cyc=%0d got=%b exp=%b", cyc, mem_rsp_valid, exp_rvalid); end
            if (exp_rvalid) begin
                checks++;
                if (mem_rsp_tag !== exp_tag || mem_rsp_data !== exp_data)
                    begin errors++; $display("FAIL rand_rsp got tag=%h data=%h exp tag=%h data=%h", mem_rsp_tag, mem_rsp_data, exp_tag, exp_data); end
            end
            hold = mem_req_valid && !exp_ready;
            advance();
        end
        mem_req_valid = 1'b0;
    endtask

    task automatic test_idle_ready();
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b1;
        for (int w = 0; w < 1000; w++) begin
            observe();
            checks++;
            if (mem_req_ready !== exp_ready) begin errors++; $display("FAIL idle_ready cyc=%0d got=%b exp=%b", cyc, mem_req_ready, exp_ready); end
            advance();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_model();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        reset_model();
        test_reset();
        test_fill();
        test_write_read();
        test_backpressure();
        test_full_stream();
        test_reset_inflight();
        test_random();
        test_idle_ready();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
